// File: rtl/cam_line_capture_pkg.sv
// Shared constants, register map, FSM states and status payload for cam_line_capture.
package cam_line_capture_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned LINE_W = 9;
    localparam int unsigned SIZE_W = 5;

    localparam logic [2:0] CMD_WR = 3'b001;
    localparam logic [2:0] CMD_RD = 3'b010;

    localparam logic [6:0] ADDR_FIFO     = 7'h00;
    localparam logic [6:0] ADDR_START    = 7'h10;
    localparam logic [6:0] ADDR_END      = 7'h14;
    localparam logic [6:0] ADDR_LADDR_LO = 7'h20;
    localparam logic [6:0] ADDR_LADDR_HI = 7'h21;
    localparam logic [6:0] ADDR_LSIZE    = 7'h30;
    localparam logic [6:0] ADDR_STATUS   = 7'h70;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_WAIT0 = 2'd1,
        ST_WAIT1 = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic [1:0] rsvd_hi;
        logic       overflow;
        logic       full;
        logic [1:0] rsvd_lo;
        logic       underflow;
        logic       empty;
    } status_t;

endpackage

// File: rtl/cam_line_capture_fifo.sv
// Async first-word-fall-through FIFO with Gray pointers and 2-flop pointer synchronizers.
// LINECAP_STATUS_EN adds the full/overflow/underflow status ports.
module cam_line_capture_fifo
    import cam_line_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 32768,
    parameter int unsigned DW    = PIX_W
) (
    input  logic          wclk_i,
    input  logic          wrst_n_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rclk_i,
    input  logic          rrst_n_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rdata_c_o,
    output logic          empty_o
`ifdef LINECAP_STATUS_EN
    ,
    output logic          full_o,
    output logic          overflow_o,
    output logic          underflow_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wbin_q, wgray_q, rgray_s1_q, rgray_s2_q;
    logic [PW-1:0] rbin_q, rgray_q, wgray_s1_q, wgray_s2_q;
    logic          full_q, empty_q;
    logic          wr_fire_c, rd_fire_c;
    logic [PW-1:0] wbin_d, rbin_d;

    assign wr_fire_c = wr_en_i & ~full_q;
    assign rd_fire_c = rd_en_i & ~empty_q;
    assign wbin_d    = wbin_q + PW'(wr_fire_c);
    assign rbin_d    = rbin_q + PW'(rd_fire_c);
    assign rdata_c_o = mem_q[rbin_q[AW-1:0]];
    assign empty_o   = empty_q;

    // Storage array; written only from the camera side.
    always_ff @(posedge wclk_i) begin
        if (wr_fire_c) mem_q[wbin_q[AW-1:0]] <= wdata_i;
    end

    // Write pointer, read-pointer synchronizer and full flag (pessimistic, registered).
    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            rgray_s1_q <= '0;
            rgray_s2_q <= '0;
            full_q     <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= bin2gray(wbin_d);
            rgray_s1_q <= rgray_q;
            rgray_s2_q <= rgray_s1_q;
            full_q     <= (wbin_d - gray2bin(rgray_s2_q)) == PW'(DEPTH);
        end
    end

    // Read pointer, write-pointer synchronizer and empty flag.
    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) begin
            rbin_q     <= '0;
            rgray_q    <= '0;
            wgray_s1_q <= '0;
            wgray_s2_q <= '0;
            empty_q    <= 1'b1;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= bin2gray(rbin_d);
            wgray_s1_q <= wgray_q;
            wgray_s2_q <= wgray_s1_q;
            empty_q    <= rbin_d == gray2bin(wgray_s2_q);
        end
    end

`ifdef LINECAP_STATUS_EN
    logic overflow_q, underflow_q;

    // One-cycle pulse on a write attempted while full.
    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) overflow_q <= 1'b0;
        else           overflow_q <= wr_en_i & full_q;
    end

    // One-cycle pulse on a read attempted while empty.
    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) underflow_q <= 1'b0;
        else           underflow_q <= rd_en_i & empty_q;
    end

    assign full_o      = full_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

endmodule

// File: rtl/cam_line_capture.sv
// Camera line capture: records a window of lines of the next frame into an async FIFO
// and exposes control/status/pixels on an OCP-style byte register bus.
// LINECAP_STATUS_EN enables FIFO status at 0x70 (otherwise 0x70 reads 0x00).
module cam_line_capture
    import cam_line_capture_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 32768
) (
    input  logic             readClk,
    input  logic             readRst_n,
    input  logic             writeClk,
    input  logic             writeRst_n,
    input  logic             VSYNC,
    input  logic             HREF,
    input  logic [PIX_W-1:0] DATA,
    input  logic [2:0]       linebuf_MCmd,
    input  logic [7:0]       linebuf_MAddr,
    input  logic [7:0]       linebuf_MData,
    output logic             linebuf_SCmdAccept,
    output logic [7:0]       linebuf_SData,
    output logic [1:0]       linebuf_SResp
);

    localparam int unsigned CFG_W = 1 + LINE_W + SIZE_W;
    localparam int unsigned SUM_W = LINE_W + 1;

    // ---------------- read (bus) domain ----------------
    logic              capture_start_q;
    logic [LINE_W-1:0] line_addr_q;
    logic [SIZE_W-1:0] line_size_q;
    logic [7:0]        sdata_q;
    logic              rvalid_q;
    logic [1:0]        end_s_q, kicked_s_q;
    logic              bus_wr_c, bus_rd_c;
    logic [6:0]        addr_c;
    logic [7:0]        rd_mux_c;
    status_t           status_c;
    logic              unused_addr_msb;

    // ---------------- write (camera) domain ----------------
    logic [CFG_W-1:0]  cfg_s1_q, cfg_s2_q;
    logic              start_s_c;
    logic [LINE_W-1:0] addr_s_c;
    logic [SIZE_W-1:0] size_s_c;
    logic              vsync_q, vsync_dly_q, href_pre_q, href_q;
    logic [PIX_W-1:0]  data_pre_q, data_q;
    logic [LINE_W-1:0] line_cnt_q;
    logic              countup_q;
    logic              frame_start_c, capture_area_c, fifo_wr_c;
    logic [SUM_W-1:0]  lo_c, hi_c, cnt_c;
    cap_state_e        state_q, state_d;
    logic              kicked_q, kicked_d, capture_end_q, capture_end_d;

    logic [PIX_W-1:0]  fifo_head_c;
    logic              fifo_empty, fifo_pop_c;

    assign bus_wr_c        = linebuf_MCmd == CMD_WR;
    assign bus_rd_c        = linebuf_MCmd == CMD_RD;
    assign addr_c          = linebuf_MAddr[6:0];
    assign unused_addr_msb = linebuf_MAddr[7];
    assign fifo_pop_c      = bus_rd_c && (addr_c == ADDR_FIFO);

    assign linebuf_SCmdAccept = 1'b1;
    assign linebuf_SData      = sdata_q;
    assign linebuf_SResp      = {1'b0, rvalid_q};

    // Software-visible control registers; a bus write beats the kick auto-clear.
    always_ff @(posedge readClk or negedge readRst_n) begin
        if (!readRst_n) begin
            capture_start_q <= 1'b0;
            line_addr_q     <= '0;
            line_size_q     <= '0;
        end else begin
            if (bus_wr_c && addr_c == ADDR_START) capture_start_q <= linebuf_MData[0];
            else if (kicked_s_q[1])               capture_start_q <= 1'b0;
            if (bus_wr_c && addr_c == ADDR_LADDR_LO) line_addr_q[7:0] <= linebuf_MData;
            if (bus_wr_c && addr_c == ADDR_LADDR_HI) line_addr_q[8]   <= linebuf_MData[0];
            if (bus_wr_c && addr_c == ADDR_LSIZE)    line_size_q      <= linebuf_MData[SIZE_W-1:0];
        end
    end

`ifdef LINECAP_STATUS_EN
    logic [1:0] full_s_q, ovf_s_q;
    logic       fifo_full, fifo_ovf, fifo_udf;

    // Bring write-side full/overflow into the bus domain.
    always_ff @(posedge readClk or negedge readRst_n) begin
        if (!readRst_n) begin
            full_s_q <= '0;
            ovf_s_q  <= '0;
        end else begin
            full_s_q <= {full_s_q[0], fifo_full};
            ovf_s_q  <= {ovf_s_q[0], fifo_ovf};
        end
    end

    // Status byte assembly.
    always_comb begin
        status_c           = '0;
        status_c.overflow  = ovf_s_q[1];
        status_c.full      = full_s_q[1];
        status_c.underflow = fifo_udf;
        status_c.empty     = fifo_empty;
    end
`else
    assign status_c = '0;
`endif

    // Read data mux; an empty-FIFO read keeps the previous SData.
    always_comb begin
        rd_mux_c = 8'h00;
        case (addr_c)
            ADDR_FIFO:     rd_mux_c = fifo_empty ? sdata_q : fifo_head_c;
            ADDR_START:    rd_mux_c = {7'b0, capture_start_q};
            ADDR_END:      rd_mux_c = {7'b0, end_s_q[1]};
            ADDR_LADDR_LO: rd_mux_c = line_addr_q[7:0];
            ADDR_LADDR_HI: rd_mux_c = {7'b0, line_addr_q[8]};
            ADDR_LSIZE:    rd_mux_c = {3'b0, line_size_q};
            ADDR_STATUS:   rd_mux_c = status_c;
            default:       rd_mux_c = 8'h00;
        endcase
    end

    // Registered read response and synchronizers from the camera domain.
    always_ff @(posedge readClk or negedge readRst_n) begin
        if (!readRst_n) begin
            sdata_q    <= 8'h00;
            rvalid_q   <= 1'b0;
            end_s_q    <= '0;
            kicked_s_q <= '0;
        end else begin
            rvalid_q   <= bus_rd_c;
            if (bus_rd_c) sdata_q <= rd_mux_c;
            end_s_q    <= {end_s_q[0], capture_end_q};
            kicked_s_q <= {kicked_s_q[0], kicked_q};
        end
    end

    // Config synchronizer and camera input pipeline.
    always_ff @(posedge writeClk or negedge writeRst_n) begin
        if (!writeRst_n) begin
            cfg_s1_q    <= '0;
            cfg_s2_q    <= '0;
            vsync_q     <= 1'b0;
            vsync_dly_q <= 1'b0;
            href_pre_q  <= 1'b0;
            href_q      <= 1'b0;
            data_pre_q  <= '0;
            data_q      <= '0;
        end else begin
            cfg_s1_q    <= {capture_start_q, line_addr_q, line_size_q};
            cfg_s2_q    <= cfg_s1_q;
            vsync_q     <= VSYNC;
            vsync_dly_q <= vsync_q;
            href_pre_q  <= HREF;
            href_q      <= href_pre_q;
            data_pre_q  <= DATA;
            data_q      <= data_pre_q;
        end
    end

    assign {start_s_c, addr_s_c, size_s_c} = cfg_s2_q;
    assign frame_start_c  = vsync_q & ~vsync_dly_q;
    assign cnt_c          = {1'b0, line_cnt_q};
    assign lo_c           = {1'b0, addr_s_c};
    assign hi_c           = lo_c + SUM_W'(size_s_c);
    assign capture_area_c = (cnt_c >= lo_c) && (cnt_c < hi_c);
    assign fifo_wr_c      = href_q & capture_area_c & (state_q != ST_INIT);

    // Line counter: first line after VSYNC is line 1.
    always_ff @(posedge writeClk or negedge writeRst_n) begin
        if (!writeRst_n) begin
            line_cnt_q <= '0;
            countup_q  <= 1'b1;
        end else if (frame_start_c) begin
            line_cnt_q <= '0;
            countup_q  <= 1'b0;
        end else if (href_pre_q && countup_q) begin
            line_cnt_q <= line_cnt_q + LINE_W'(1);
            countup_q  <= 1'b0;
        end else if (!href_pre_q) begin
            countup_q  <= 1'b1;
        end
    end

    // Capture FSM state register.
    always_ff @(posedge writeClk or negedge writeRst_n) begin
        if (!writeRst_n) begin
            state_q       <= ST_INIT;
            kicked_q      <= 1'b0;
            capture_end_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            kicked_q      <= kicked_d;
            capture_end_q <= capture_end_d;
        end
    end

    // Capture FSM next state: arm on frame start, record the window, flag completion.
    always_comb begin
        state_d       = state_q;
        kicked_d      = kicked_q;
        capture_end_d = capture_end_q;
        if (!start_s_c) kicked_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (start_s_c && frame_start_c) begin
                    state_d       = ST_WAIT0;
                    kicked_d      = 1'b1;
                    capture_end_d = 1'b0;
                end
            end
            ST_WAIT0: if (capture_area_c) state_d = ST_WAIT1;
            ST_WAIT1: begin
                if (!capture_area_c) begin
                    state_d       = ST_INIT;
                    capture_end_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    cam_line_capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (PIX_W)
    ) u_fifo (
        .wclk_i      (writeClk),
        .wrst_n_i    (writeRst_n),
        .wr_en_i     (fifo_wr_c),
        .wdata_i     (data_q),
        .rclk_i      (readClk),
        .rrst_n_i    (readRst_n),
        .rd_en_i     (fifo_pop_c),
        .rdata_c_o   (fifo_head_c),
        .empty_o     (fifo_empty)
`ifdef LINECAP_STATUS_EN
        ,
        .full_o      (fifo_full),
        .overflow_o  (fifo_ovf),
        .underflow_o (fifo_udf)
`endif
    );

endmodule

// File: tb/tb_cam_line_capture.sv
// Directed bench for cam_line_capture (FIFO_DEPTH=16 so overflow is reachable).
module tb_cam_line_capture;

`ifdef LINECAP_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic       readClk, readRst_n, writeClk, writeRst_n;
    logic       VSYNC, HREF;
    logic [7:0] DATA;
    logic [2:0] MCmd;
    logic [7:0] MAddr, MData;
    logic       SCmdAccept;
    logic [7:0] SData;
    logic [1:0] SResp;

    int checks = 0;
    int passes = 0;

    cam_line_capture #(.FIFO_DEPTH(16)) dut (
        .readClk            (readClk),
        .readRst_n          (readRst_n),
        .writeClk           (writeClk),
        .writeRst_n         (writeRst_n),
        .VSYNC              (VSYNC),
        .HREF               (HREF),
        .DATA               (DATA),
        .linebuf_MCmd       (MCmd),
        .linebuf_MAddr      (MAddr),
        .linebuf_MData      (MData),
        .linebuf_SCmdAccept (SCmdAccept),
        .linebuf_SData      (SData),
        .linebuf_SResp      (SResp)
    );

    initial readClk = 1'b0;
    always #5 readClk = ~readClk;
    initial writeClk = 1'b0;
    always #7 writeClk = ~writeClk;

    // Expected status byte: {2'b00, ovf, full, 2'b00, udf, empty}, zero when status is compiled out.
    function automatic logic [7:0] st(input logic ovf, input logic full, input logic udf, input logic emp);
        return STATUS_EN ? {2'b00, ovf, full, 2'b00, udf, emp} : 8'h00;
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge readClk);
        MCmd = 3'b001; MAddr = a; MData = d;
        @(posedge readClk); #1;
        MCmd = 3'b000;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic [1:0] r);
        @(negedge readClk);
        MCmd = 3'b010; MAddr = a;
        @(posedge readClk); #1;
        d = SData; r = SResp;
        MCmd = 3'b000;
    endtask

    // One frame: VSYNC pulse then nlines lines of npix pixels, pixel = line*16+pix.
    task automatic drive_frame(input int nlines, input int npix);
        @(posedge writeClk); #1 VSYNC = 1'b1;
        repeat (3) @(posedge writeClk);
        #1 VSYNC = 1'b0;
        repeat (4) @(posedge writeClk);
        for (int l = 1; l <= nlines; l++) begin
            for (int p = 0; p < npix; p++) begin
                @(posedge writeClk); #1;
                HREF = 1'b1; DATA = 8'(l * 16 + p);
            end
            @(posedge writeClk); #1;
            HREF = 1'b0; DATA = 8'h00;
            repeat (4) @(posedge writeClk);
        end
        repeat (6) @(posedge writeClk);
    endtask

    task automatic test_reset();
        logic [7:0] addrs [6];
        logic [7:0] d;
        logic [1:0] r;
        addrs = '{8'h10, 8'h14, 8'h20, 8'h21, 8'h30, 8'h44};
        readRst_n = 1'b0; writeRst_n = 1'b0;
        VSYNC = 1'b0; HREF = 1'b0; DATA = 8'h00;
        MCmd = 3'b000; MAddr = 8'h00; MData = 8'h00;
        repeat (4) @(posedge readClk);
        @(negedge readClk);
        readRst_n = 1'b1; writeRst_n = 1'b1;
        repeat (3) @(posedge readClk);
        #1;
        checks++; if (SData !== 8'h00) $display("FAIL reset_sdata: got %h want 00", SData); else passes++;
        checks++; if (SResp !== 2'b00) $display("FAIL reset_sresp: got %b want 00", SResp); else passes++;
        checks++; if (SCmdAccept !== 1'b1) $display("FAIL cmd_accept: got %b want 1", SCmdAccept); else passes++;
        for (int i = 0; i < 6; i++) begin
            bus_read(addrs[i], d, r);
            checks++; if (d !== 8'h00) $display("FAIL reset_reg_%h: got %h want 00", addrs[i], d); else passes++;
            checks++; if (r !== 2'b01) $display("FAIL reset_resp_%h: got %b want 01", addrs[i], r); else passes++;
        end
        @(posedge readClk); #1;
        checks++; if (SResp !== 2'b00) $display("FAIL idle_resp: got %b want 00", SResp); else passes++;
        bus_read(8'h70, d, r);
        checks++; if (d !== st(0, 0, 0, 1)) $display("FAIL reset_status: got %h want %h", d, st(0, 0, 0, 1)); else passes++;
    endtask

    task automatic test_capture();
        logic [7:0] d;
        logic [1:0] r;
        bus_write(8'h20, 8'h03);
        bus_write(8'h21, 8'h00);
        bus_write(8'h30, 8'h02);
        bus_write(8'h10, 8'h01);
        bus_read(8'h20, d, r);
        checks++; if (d !== 8'h03) $display("FAIL laddr_rb: got %h want 03", d); else passes++;
        bus_read(8'h30, d, r);
        checks++; if (d !== 8'h02) $display("FAIL lsize_rb: got %h want 02", d); else passes++;
        bus_read(8'h10, d, r);
        checks++; if (d !== 8'h01) $display("FAIL start_armed: got %h want 01", d); else passes++;
        repeat (10) @(posedge readClk);
        drive_frame(5, 4);
        repeat (20) @(posedge readClk);
        bus_read(8'h14, d, r);
        checks++; if (d !== 8'h01) $display("FAIL capture_end: got %h want 01", d); else passes++;
        bus_read(8'h10, d, r);
        checks++; if (d !== 8'h00) $display("FAIL start_autoclr: got %h want 00", d); else passes++;
        bus_read(8'h70, d, r);
        checks++; if (d !== st(0, 0, 0, 0)) $display("FAIL cap_status: got %h want %h", d, st(0, 0, 0, 0)); else passes++;
    endtask

    task automatic test_drain_underflow();
        logic [7:0] exp [8];
        logic [7:0] d;
        logic [1:0] r;
        exp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 8; i++) begin
            bus_read(8'h00, d, r);
            checks++; if (d !== exp[i]) $display("FAIL pop_%0d: got %h want %h", i, d, exp[i]); else passes++;
        end
        bus_read(8'h00, d, r);
        checks++; if (d !== 8'h43) $display("FAIL empty_hold: got %h want 43", d); else passes++;
        checks++; if (r !== 2'b01) $display("FAIL empty_resp: got %b want 01", r); else passes++;
        bus_read(8'h70, d, r);
        checks++; if (d !== st(0, 0, 1, 1)) $display("FAIL underflow: got %h want %h", d, st(0, 0, 1, 1)); else passes++;
        bus_read(8'h70, d, r);
        checks++; if (d !== st(0, 0, 0, 1)) $display("FAIL udf_clear: got %h want %h", d, st(0, 0, 0, 1)); else passes++;
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic [1:0] r;
        bit done = 1'b0;
        bit seen = 1'b0;
        int n = 0;
        bus_write(8'h20, 8'h01);
        bus_write(8'h30, 8'h01);
        bus_write(8'h10, 8'h01);
        repeat (10) @(posedge readClk);
        fork
            begin
                drive_frame(2, 20);
                done = 1'b1;
            end
            begin
                while (!done && n < 2000) begin
                    bus_read(8'h70, d, r);
                    if (d === st(1, 1, 0, 0)) seen = 1'b1;
                    n++;
                end
            end
        join
        checks++; if (!seen) $display("FAIL ovf_seen: got 0 want 1 (status %h)", st(1, 1, 0, 0)); else passes++;
        repeat (20) @(posedge readClk);
        bus_read(8'h70, d, r);
        checks++; if (d !== st(0, 1, 0, 0)) $display("FAIL full_hold: got %h want %h", d, st(0, 1, 0, 0)); else passes++;
        bus_read(8'h14, d, r);
        checks++; if (d !== 8'h01) $display("FAIL ovf_end: got %h want 01", d); else passes++;
        for (int i = 0; i < 16; i++) begin
            bus_read(8'h00, d, r);
            checks++; if (d !== 8'(16 + i)) $display("FAIL ovf_pop_%0d: got %h want %h", i, d, 8'(16 + i)); else passes++;
        end
        repeat (20) @(posedge readClk);
        bus_read(8'h70, d, r);
        checks++; if (d !== st(0, 0, 0, 1)) $display("FAIL ovf_drained: got %h want %h", d, st(0, 0, 0, 1)); else passes++;
    endtask

    task automatic test_idle_frame();
        logic [7:0] d;
        logic [1:0] r;
        logic [7:0] worst;
        bit done = 1'b0;
        int n = 0;
        worst = st(0, 0, 0, 1);
        bus_write(8'h20, 8'h00);
        bus_write(8'h30, 8'h1F);
        bus_read(8'h10, d, r);
        checks++; if (d !== 8'h00) $display("FAIL idle_start: got %h want 00", d); else passes++;
        fork
            begin
                drive_frame(3, 4);
                done = 1'b1;
            end
            begin
                while (!done && n < 2000) begin
                    bus_read(8'h70, d, r);
                    if (d !== st(0, 0, 0, 1)) worst = d;
                    n++;
                end
            end
        join
        checks++; if (worst !== st(0, 0, 0, 1)) $display("FAIL idle_status: got %h want %h", worst, st(0, 0, 0, 1)); else passes++;
        repeat (20) @(posedge readClk);
        bus_read(8'h70, d, r);
        checks++; if (d !== st(0, 0, 0, 1)) $display("FAIL idle_empty: got %h want %h", d, st(0, 0, 0, 1)); else passes++;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_drain_underflow();
        test_overflow();
        test_idle_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/cam_line_capture.md
# cam_line_capture

Camera line-capture block: samples an 8-bit parallel camera stream (VSYNC/HREF/DATA) on writeClk, stores a programmable window of lines in an asynchronous FWFT FIFO, and exposes control, status and pixel data to an OCP-style 8-bit register bus on readClk. It sits between the image-sensor pads and the system bus. Software arms a capture, and the block records lines [line_addr, line_addr+line_size) of the next frame.

## Interface
- FIFO_DEPTH, 32768: FIFO words (power of two); pointer width is log2(FIFO_DEPTH)+1.
- readClk in 1: bus clock.
- readRst_n in 1: reset, asynchronous, active-low; clock readClk.
- writeClk in 1: camera pixel clock.
- writeRst_n in 1: camera-domain reset, asynchronous, active-low.
- VSYNC in 1: frame sync (rising edge = frame start).
- HREF in 1: line valid.
- DATA in 8: pixel byte.
- linebuf_MCmd in 3: 3'b001 write, 3'b010 read, other values idle.
- linebuf_MAddr in 8: register address; only bits [6:0] decoded.
- linebuf_MData in 8: write data.
- linebuf_SCmdAccept out 1: constant 1.
- linebuf_SData out 8: registered read data.
- linebuf_SResp out 2: {1'b0, read_valid}.

## Operation
- Register map (MAddr[6:0]):
  - 0x00 R: FIFO head byte; pops one word.
  - 0x10 RW bit0: capture_start.
  - 0x14 R bit0: capture_end.
  - 0x20 RW: line_addr[7:0].
  - 0x21 RW bit0: line_addr[8].
  - 0x30 RW [4:0]: line_size.
  - 0x70 R: {2'b00, overflow, full, 2'b00, underflow, empty}.
  - Unmapped reads return 0x00; unmapped writes are ignored.
- capture_start: a bus write has priority. Otherwise it clears when the synchronized kicked flag is 1.
- Camera inputs are registered:
  - VSYNC: 1 stage.
  - HREF and DATA: 2 stages (HREF_pre then HREF, DATA_pre then DATA).
- frame_start = r_VSYNC & ~r_VSYNC_d, a 1-cycle pulse.
- Line counter (9b, resets to 0, countup resets to 1):
  - On frame_start: count = 0, countup = 0.
  - Else if HREF_pre and countup: count + 1, countup = 0.
  - Else if !HREF_pre: countup = 1.
  - The first line after VSYNC is therefore numbered 1.
- capture_area = count >= line_addr && count < line_addr + line_size. The sum is computed in 10 bits with no wrap.
- FSM (writeClk):
  - INIT: if sync(capture_start) & frame_start, go to WAIT0, set kicked = 1 and capture_end = 0.
  - WAIT0: if capture_area, go to WAIT1.
  - WAIT1: if !capture_area, go to INIT and set capture_end = 1 (sticky until the next kick).
  - kicked clears when sync(capture_start) == 0, in any state.
- FIFO write enable = r_HREF & capture_area & (state is WAIT0 or WAIT1). Write data is r_DATA.
- FIFO (first-word-fall-through, Gray-coded pointers, 2-flop pointer synchronizers):
  - full and overflow live in the write domain. overflow is a 1-cycle pulse on a write while full; the write is dropped.
  - empty and underflow live in the read domain. underflow is a 1-cycle pulse on a read while empty; there is no pop and SData keeps the stale head value.
- Cross-domain signals use 2-flop synchronizers:
  - Into writeClk: capture_start, line_addr, line_size. Multi-bit skew is tolerated; software changes these only while idle.
  - Into readClk: capture_end, kicked, full, overflow.

## Timing
- Bus read: SData and SResp=2'b01 are valid on the readClk edge after the read cycle. SResp=2'b00 otherwise.
- Writes take effect on the next readClk edge. There are no wait states.
- Reset values: SData 0x00, SResp 0, all registers 0, FSM INIT, FIFO empty.
- Pixel path: DATA to FIFO write is 2 writeClk cycles. A written word reaches the read side (empty deasserts) ≤4 readClk cycles later.
- Arm-to-kick: capture_start needs 2 writeClk cycles to synchronize. It auto-clears ≤3 readClk cycles after kick.
- Simultaneous bus write of capture_start and an auto-clear: the bus write wins.
- A reset mid-capture in either domain returns that domain to its reset state. The FIFO empties.

## Configuration
- LINECAP_STATUS_EN:
  - Defined: register 0x70 returns FIFO status, and the full/overflow synchronizers exist.
  - Undefined: 0x70 reads 0x00, and the synchronizers and underflow/overflow logic are removed.

## Structure
- Shared package `cam_line_capture_pkg`:
  - Command codes: CMD_WR=3'b001, CMD_RD=3'b010.
  - Register address constants.
  - FSM state enum: INIT=0, WAIT0=1, WAIT1=2.
- Sub-module `cam_line_capture_fifo`: parameterized async FWFT FIFO.
- Synchronizers and the edge detector are inline generate/always blocks.

## Test plan
- Reset: read 0x10/0x14/0x20/0x30 -> 0x00 each, SResp=01 one cycle after each read. Read 0x70 -> 0x01 (empty).
- Write line_addr=0x003, line_size=2, capture_start=1. Drive a frame of 5 lines × 4 pixels (data = line*16+pix). Expected:
  - FIFO receives 8 bytes 0x30..0x33, 0x40..0x43.
  - 0x14 reads 1.
  - 0x10 reads 0.
- After that capture, read 0x00 eight times -> 0x30,0x31,0x32,0x33,0x40,0x41,0x42,0x43. The next read of 0x70 shows empty=1.
- Read 0x00 on empty FIFO -> 0x70 bit1 (underflow) pulses. SData is unchanged from the previous head value.
- FIFO_DEPTH=16, capture 1 line of 20 pixels -> 0x70 reads 0x30 (full+overflow captured while pulsing). Exactly 16 bytes are readable.
- capture_start=0 while frames run -> no FIFO writes; 0x70 stays 0x01.
